// File: rtl/uart_mmio_ctrl_pkg.sv
// Register offsets, STATUS bit positions and the address decoder shared by the
// UART MMIO controller.
package uart_mmio_ctrl_pkg;

    localparam logic [31:0] UART_STATUS_OFF = 32'h0;
    localparam logic [31:0] UART_RX_OFF     = 32'h4;
    localparam logic [31:0] UART_TX_OFF     = 32'h8;
    localparam logic [31:0] UART_CLR_OFF    = 32'hC;

    localparam int STAT_TX_NOTFULL  = 0;
    localparam int STAT_RX_NONEMPTY = 1;
    localparam int STAT_RX_UNF      = 2;
    localparam int STAT_TX_OVF      = 3;

    typedef enum logic [2:0] {
        REG_STATUS,
        REG_RX,
        REG_TX,
        REG_CLR,
        REG_NONE
    } reg_sel_e;

    // Full 32-bit match so aliases outside the window never hit a register.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
        if (addr == base + UART_STATUS_OFF) return REG_STATUS;
        if (addr == base + UART_RX_OFF)     return REG_RX;
        if (addr == base + UART_TX_OFF)     return REG_TX;
        if (addr == base + UART_CLR_OFF)    return REG_CLR;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with registered storage; the head is readable in the same
// cycle it becomes valid and reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; stale entries are masked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-facing MMIO window for the UART core: TX/RX FIFOs, sticky overflow and
// underflow flags, and a combinational register read mux.
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmio_addr,
    input  logic        mmio_re,
    input  logic        mmio_we,
    input  logic [7:0]  mmio_wdata,
    output logic [31:0] mmio_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    reg_sel_e    sel;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [AW:0] tx_count, rx_count;
    logic [7:0]  rx_head;
    logic        tx_wr, tx_rd, rx_wr, rx_rd;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_unf_q, rx_unf_d;
    logic        tx_notfull, rx_nonempty;

    assign sel = decode_addr(mmio_addr, BASE_ADDR);

    assign uart_tx_valid = !tx_empty;
    assign uart_rx_ready = !rx_full;
    assign tx_wr = mmio_we && (sel == REG_TX) && !tx_full;
    assign tx_rd = uart_tx_valid && uart_tx_ready;
    assign rx_wr = uart_rx_valid && uart_rx_ready;
    assign rx_rd = mmio_re && (sel == REG_RX) && !rx_empty;

    assign tx_notfull  = (tx_count != (AW+1)'(FIFO_DEPTH));
    assign rx_nonempty = (rx_count != '0);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (tx_wr),
        .din   (mmio_wdata),
        .full  (tx_full),
        .rd_en (tx_rd),
        .dout  (uart_tx_data),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (rx_wr),
        .din   (uart_rx_data),
        .full  (rx_full),
        .rd_en (rx_rd),
        .dout  (rx_head),
        .empty (rx_empty),
        .count (rx_count)
    );

    // A CLEAR store wins over an overflow/underflow raised in the same cycle.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (mmio_we && (sel == REG_TX) && tx_full)  tx_ovf_d = 1'b1;
        if (mmio_re && (sel == REG_RX) && rx_empty) rx_unf_d = 1'b1;
        if (mmio_we && (sel == REG_CLR)) begin
            tx_ovf_d = 1'b0;
            rx_unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (sel)
            REG_STATUS: begin
                mmio_rdata[STAT_TX_NOTFULL]  = tx_notfull;
                mmio_rdata[STAT_RX_NONEMPTY] = rx_nonempty;
                mmio_rdata[STAT_RX_UNF]      = rx_unf_q;
                mmio_rdata[STAT_TX_OVF]      = tx_ovf_q;
            end
            REG_RX:  mmio_rdata = {24'b0, rx_head};
            default: mmio_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed and randomized checks of uart_mmio_ctrl against a queue-based
// model of the register window and both FIFOs.
module tb_uart_mmio_ctrl;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] A_ST  = BASE + 32'h0;
    localparam logic [31:0] A_RX  = BASE + 32'h4;
    localparam logic [31:0] A_TX  = BASE + 32'h8;
    localparam logic [31:0] A_CLR = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mmio_addr;
    logic        mmio_re, mmio_we;
    logic [7:0]  mmio_wdata;
    logic [31:0] mmio_rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid, uart_rx_ready;

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic       m_ovf, m_unf;

    always #5 clk = ~clk;

    uart_mmio_ctrl #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_addr     (mmio_addr),
        .mmio_re       (mmio_re),
        .mmio_we       (mmio_we),
        .mmio_wdata    (mmio_wdata),
        .mmio_rdata    (mmio_rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a == A_ST)
            return {28'b0, m_ovf, m_unf, rx_q.size() != 0, tx_q.size() != DEPTH};
        if (a == A_RX)
            return (rx_q.size() != 0) ? {24'b0, rx_q[0]} : 32'h0;
        return 32'h0;
    endfunction

    function automatic void model_clear();
        tx_q.delete();
        rx_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // One clock: compare outputs mid-cycle, advance the model, step past the edge.
    task automatic cyc();
        logic tx_full, rx_full, tx_st, rx_ld;
        @(negedge clk);
        chk("rdata", mmio_rdata, model_rdata(mmio_addr));
        chk("tx_valid", 32'(uart_tx_valid), 32'(tx_q.size() != 0));
        chk("tx_data", 32'(uart_tx_data), (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'h0);
        chk("rx_ready", 32'(uart_rx_ready), 32'(rx_q.size() != DEPTH));
        if (rst) begin
            model_clear();
        end else begin
            tx_full = (tx_q.size() == DEPTH);
            rx_full = (rx_q.size() == DEPTH);
            tx_st   = mmio_we && (mmio_addr == A_TX);
            rx_ld   = mmio_re && (mmio_addr == A_RX);
            if (tx_q.size() != 0 && uart_tx_ready) void'(tx_q.pop_front());
            if (tx_st && !tx_full) tx_q.push_back(mmio_wdata);
            if (tx_st && tx_full) m_ovf = 1'b1;
            if (rx_ld && rx_q.size() != 0) void'(rx_q.pop_front());
            else if (rx_ld) m_unf = 1'b1;
            if (uart_rx_valid && !rx_full) rx_q.push_back(uart_rx_data);
            if (mmio_we && (mmio_addr == A_CLR)) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic re, input logic we, input logic [31:0] a, input logic [7:0] d);
        mmio_re    = re;
        mmio_we    = we;
        mmio_addr  = a;
        mmio_wdata = d;
    endtask

    initial begin
        logic [31:0] roff [5];
        roff = '{A_ST, A_RX, A_TX, A_CLR, BASE + 32'h10};
        rst = 1'b1;
        bus(1'b0, 1'b0, 32'h0, 8'h00);
        uart_tx_ready = 1'b0;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        bus(1'b0, 1'b0, A_ST, 8'h00);
        #1;
        chk("rst_status", mmio_rdata, 32'h1);
        chk("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
        chk("rst_tx_data", 32'(uart_tx_data), 32'h0);

        // Single store then one-cycle drain
        bus(1'b0, 1'b1, A_TX, 8'h41);
        cyc();
        bus(1'b0, 1'b0, A_ST, 8'h00);
        #1;
        chk("tx1_valid", 32'(uart_tx_valid), 32'h1);
        chk("tx1_data", 32'(uart_tx_data), 32'h41);
        uart_tx_ready = 1'b1;
        cyc();
        uart_tx_ready = 1'b0;
        #1;
        chk("tx1_drained", 32'(uart_tx_valid), 32'h0);

        // Nine stores into an eight-deep FIFO
        for (int i = 0; i < 9; i++) begin
            bus(1'b0, 1'b1, A_TX, 8'(i));
            cyc();
            bus(1'b0, 1'b0, A_ST, 8'h00);
            #1;
            if (i == 7) chk("tx_full_bit0", 32'(mmio_rdata[0]), 32'h0);
            if (i == 8) chk("tx_ovf_bit3", 32'(mmio_rdata[3]), 32'h1);
        end
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tx_drain_order", 32'(uart_tx_data), 32'(i));
            cyc();
        end
        uart_tx_ready = 1'b0;
        #1;
        chk("tx_drain_empty", 32'(uart_tx_valid), 32'h0);
        bus(1'b0, 1'b1, A_CLR, 8'h00);
        cyc();

        // Two RX bytes read back, then underflow
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h55;
        cyc();
        uart_rx_data = 8'hAA;
        cyc();
        uart_rx_valid = 1'b0;
        bus(1'b0, 1'b0, A_ST, 8'h00);
        #1;
        chk("rx_nonempty", 32'(mmio_rdata[1]), 32'h1);
        bus(1'b1, 1'b0, A_RX, 8'h00);
        #1;
        chk("rx_load1", mmio_rdata, 32'h55);
        cyc();
        chk("rx_load2", mmio_rdata, 32'hAA);
        cyc();
        chk("rx_load3", mmio_rdata, 32'h0);
        cyc();
        bus(1'b0, 1'b0, A_ST, 8'h00);
        #1;
        chk("rx_unf_bit2", 32'(mmio_rdata[2]), 32'h1);
        bus(1'b0, 1'b1, A_CLR, 8'h00);
        cyc();
        bus(1'b0, 1'b0, A_ST, 8'h00);
        #1;
        chk("clear_status", mmio_rdata, 32'h1);

        // RX backpressure
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            uart_rx_data = 8'h10 + 8'(i);
            cyc();
        end
        uart_rx_data = 8'h99;
        #1;
        chk("rx_full_ready", 32'(uart_rx_ready), 32'h0);
        cyc();
        bus(1'b1, 1'b0, A_RX, 8'h00);
        #1;
        chk("rx_full_head", mmio_rdata, 32'h10);
        cyc();
        bus(1'b0, 1'b0, A_ST, 8'h00);
        #1;
        chk("rx_ready_after_load", 32'(uart_rx_ready), 32'h1);
        cyc();
        uart_rx_valid = 1'b0;
        #1;
        chk("rx_refilled", 32'(uart_rx_ready), 32'h0);
        bus(1'b1, 1'b0, A_RX, 8'h00);
        repeat (8) cyc();
        bus(1'b0, 1'b0, A_ST, 8'h00);

        // Reset in the middle of a TX drain
        for (int i = 0; i < 3; i++) begin
            bus(1'b0, 1'b1, A_TX, 8'hC0 + 8'(i));
            cyc();
        end
        bus(1'b0, 1'b0, A_ST, 8'h00);
        uart_tx_ready = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        uart_tx_ready = 1'b0;
        #1;
        chk("rst_mid_tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("rst_mid_status", mmio_rdata, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                roff[$urandom_range(0, 4)], 8'($urandom));
            uart_tx_ready = ($urandom_range(0, 2) == 0);
            uart_rx_valid = ($urandom_range(0, 1) == 0);
            uart_rx_data  = 8'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rst = 1'b0;
        bus(1'b0, 1'b0, A_ST, 8'h00);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Sequences the on-chip UART core on behalf of the CPU memory-mapped IO path.
- Decouples CPU loads/stores from the serial rate with one TX FIFO and one RX FIFO.
- Drives the UART core's ready/valid handshakes and presents status and data registers at 0x8000_0000–0x8000_000C.
- Sits between the core's MMIO decode and the uart instance. Replaces direct combinational ready/valid generation.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2.
- BASE_ADDR, 32'h8000_0000, base of the register window.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- mmio_addr  in  32  byte address from execute stage
- mmio_re  in  1  load strobe, qualified by mmio_addr
- mmio_we  in  1  store strobe, qualified by mmio_addr
- mmio_wdata  in  8  store data, low byte
- mmio_rdata  out  32  load data, combinational from mmio_addr
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter accepts byte
- uart_rx_data  in  8  byte from UART receiver
- uart_rx_valid  in  1  receiver holds byte
- uart_rx_ready  out  1  RX FIFO can accept

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: both FIFOs empty, pointers and counts 0, sticky flags 0. uart_tx_valid=0, uart_rx_ready=1, uart_tx_data=0. mmio_rdata follows the address decode of reset state.
- Register map (offset from BASE_ADDR):
  - +0x0 STATUS, read-only: {28'b0, tx_ovf, rx_unf, rx_nonempty, tx_notfull}. Bits 1:0 keep the legacy control-register layout.
  - +0x4 RX_DATA: {24'b0, rx head} when rx_nonempty, else 0.
  - +0x8 TX_DATA: write-only, reads 0.
  - +0xC CLEAR: any write clears tx_ovf and rx_unf; reads 0.
  - Any other address reads 0.
- TX push: mmio_we && addr==+0x8 && !tx_full at cycle start → mmio_wdata enqueued at posedge.
  - If full: byte dropped, tx_ovf<=1. A same-cycle UART pop does not rescue it; fullness is sampled pre-edge.
- TX drain: uart_tx_valid=!tx_empty; uart_tx_data=tx head (registered-storage read, no bubble). Pop on uart_tx_valid && uart_tx_ready.
- RX fill: uart_rx_ready=!rx_full. Push uart_rx_data on uart_rx_valid && uart_rx_ready.
- RX pop: mmio_re && addr==+0x4 && !rx_empty → head removed at posedge. The same cycle's mmio_rdata shows the pre-pop head (load sees the value, then it pops).
  - If empty: returns 0, no pop, rx_unf<=1.
- Simultaneous push and pop on one FIFO in the same cycle: both occur, count unchanged. Legal at empty for TX only if the push is visible next cycle. No write-through: an empty FIFO never presents same-cycle push data.
- Latency: CPU store to uart_tx_valid high = 1 cycle. uart_rx_valid handshake to rx_nonempty = 1 cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits; full ⇔ count==FIFO_DEPTH.
- Sticky flags: CLEAR write takes priority over a same-cycle set.
- mmio_re/mmio_we asserted together at different addresses: both act independently.
- Reset mid-transfer discards queued bytes; the UART core is reset by the same rst.

Decomposition:
- Shared package/header uart_mmio_defs.vh holds:
  - offsets UART_STATUS_OFF=0x0, UART_RX_OFF=0x4, UART_TX_OFF=0x8, UART_CLR_OFF=0xC;
  - STATUS bit indices.
- One reusable sub-module, sync_fifo (params WIDTH, DEPTH; ports clk, rst, wr_en, din, full, rd_en, dout, empty, count). Instantiated twice (TX, RX).
- Top level holds decode, sticky flags and read mux.

Test Plan:
- Reset, then read +0x0 → 32'h1 (tx_notfull=1, others 0); uart_tx_valid=0, uart_rx_ready=1.
- Store 0x41 to +0x8 with uart_tx_ready=0 → next cycle uart_tx_valid=1, uart_tx_data=0x41. Raise ready one cycle → valid drops and the FIFO is empty.
- 9 stores (0x00..0x08) with uart_tx_ready=0, FIFO_DEPTH=8 → STATUS bit0=0 after the 8th, bit3=1 after the 9th. Drain yields 0x00..0x07 in order, never 0x08.
- RX pushes of 0x55 then 0xAA → STATUS bit1=1. Load +0x4 returns 0x55, next load returns 0xAA, third load returns 0 and sets bit2.
- 8 RX bytes with no loads → uart_rx_ready=0. uart_rx_valid held high; the 9th byte is not accepted until one load, then accepted the next cycle.
- Assert rst mid-drain with 3 queued TX bytes → next cycle uart_tx_valid=0, STATUS=32'h1. A CLEAR write with rx_unf=1 → STATUS bit2=0.
